// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: tag/select width derivation and default widths.
package rob_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int NWB_DEF    = 2;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    function automatic int sel_w_f(input int depth);
        return $clog2(depth);
    endfunction

    // One extra tag bit lets the all-ones code mean "no producer".
    function automatic int tag_w_f(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int TAG_W_DEF = tag_w_f(DEPTH_DEF);
    localparam logic [TAG_W_DEF-1:0] TAG_FREE = '1;

endpackage

// File: rtl/rob_lookup.sv
// Single-operand lookup: no-producer tag, same-cycle writeback bypass, else stored state.
module rob_lookup
    import rob_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NWB    = NWB_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = tag_w_f(DEPTH)
) (
    input  logic [TAG_W-1:0]        tag_i,
    input  logic [NWB-1:0]          wb_en_i,
    input  logic [NWB*TAG_W-1:0]    wb_tag_i,
    input  logic [NWB*DATA_W-1:0]   wb_data_i,
    input  logic [DEPTH-1:0]        occ_i,
    input  logic [DEPTH-1:0]        valid_i,
    input  logic [DEPTH*DATA_W-1:0] data_i,
    output logic                    ready_o,
    output logic [DATA_W-1:0]       data_o
);

    localparam int SEL_W = sel_w_f(DEPTH);
    localparam logic [TAG_W-1:0] FREE = '1;

    logic [SEL_W-1:0] idx;

    always_comb begin
        idx     = tag_i[SEL_W-1:0];
        ready_o = 1'b0;
        data_o  = '0;
        if (tag_i == FREE) begin
            ready_o = 1'b1;
        end else if (occ_i[idx]) begin
            ready_o = valid_i[idx];
            data_o  = data_i[int'(idx)*DATA_W +: DATA_W];
            // Later ports override earlier ones, so the highest index wins.
            for (int i = 0; i < NWB; i++) begin
                if (wb_en_i[i] && (wb_tag_i[i*TAG_W +: TAG_W] == tag_i)) begin
                    ready_o = 1'b1;
                    data_o  = wb_data_i[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buf.sv
// Circular reorder buffer: in-order allocate/commit, out-of-order writeback, 3 operand lookups.
module reorder_buf
    import rob_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NWB    = NWB_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    localparam int SEL_W = sel_w_f(DEPTH),
    localparam int TAG_W = tag_w_f(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_en,
    input  logic [REG_W-1:0]      alloc_dest,
    output logic [TAG_W-1:0]      alloc_tag,
    output logic                  rob_free,
    output logic [SEL_W:0]        count,
    input  logic [3*TAG_W-1:0]    lk_tag,
    output logic [2:0]            lk_ready,
    output logic [3*DATA_W-1:0]   lk_data,
    input  logic [NWB-1:0]        wb_en,
    input  logic [NWB*TAG_W-1:0]  wb_tag,
    input  logic [NWB*DATA_W-1:0] wb_data,
    input  logic                  com_stall,
    output logic                  com_en,
    output logic [REG_W-1:0]      com_addr,
    output logic [DATA_W-1:0]     com_data,
    output logic [TAG_W-1:0]      com_tag
);

    localparam logic [TAG_W-1:0] FREE      = '1;
    localparam logic [SEL_W-1:0] PTR_ONE   = 1;
    localparam logic [SEL_W:0]   CNT_ONE   = 1;
    localparam logic [SEL_W:0]   CNT_DEPTH = (SEL_W+1)'(DEPTH);

    logic [SEL_W-1:0]  head_q, head_d;
    logic [SEL_W-1:0]  tail_q, tail_d;
    logic [SEL_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [REG_W-1:0]  dest_q [DEPTH];

    logic [DEPTH-1:0]        occ;
    logic [SEL_W-1:0]        offs;
    logic [NWB-1:0]          wb_ok;
    logic [SEL_W-1:0]        wb_idx [NWB];
    logic [DEPTH*DATA_W-1:0] data_flat;
    logic                    alloc_ok;

    assign rob_free  = (count_q < CNT_DEPTH);
    assign count     = count_q;
    assign alloc_tag = {1'b0, tail_q};
    assign alloc_ok  = alloc_en && rob_free && !flush;
    assign com_en    = valid_q[head_q] && (count_q != '0) && !com_stall && !flush;
    assign com_tag   = {1'b0, head_q};
    assign com_addr  = dest_q[head_q];
    assign com_data  = data_q[head_q];

    // An entry is occupied when its distance from head is below the occupancy count.
    always_comb begin
        offs      = '0;
        occ       = '0;
        data_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs   = SEL_W'(i) - head_q;
            occ[i] = ({1'b0, offs} < count_q);
            data_flat[i*DATA_W +: DATA_W] = data_q[i];
        end
        for (int i = 0; i < NWB; i++) begin
            wb_idx[i] = wb_tag[i*TAG_W +: SEL_W];
            wb_ok[i]  = wb_en[i] && (wb_tag[i*TAG_W +: TAG_W] != FREE) && occ[wb_idx[i]];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            for (int i = 0; i < NWB; i++) begin
                if (wb_ok[i]) valid_d[wb_idx[i]] = 1'b1;
            end
            if (com_en) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PTR_ONE;
            end
            if (alloc_ok) begin
                valid_d[tail_q] = 1'b0;
                tail_d          = tail_q + PTR_ONE;
            end
            case ({alloc_ok, com_en})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload arrays carry no reset; occupancy/valid decide whether contents matter.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (alloc_ok) begin
                data_q[tail_q] <= '0;
                dest_q[tail_q] <= alloc_dest;
            end
            for (int i = 0; i < NWB; i++) begin
                if (wb_ok[i]) data_q[wb_idx[i]] <= wb_data[i*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_lookup
        rob_lookup #(
            .DEPTH (DEPTH),
            .NWB   (NWB),
            .DATA_W(DATA_W),
            .TAG_W (TAG_W)
        ) u_lookup (
            .tag_i    (lk_tag[g*TAG_W +: TAG_W]),
            .wb_en_i  (wb_en),
            .wb_tag_i (wb_tag),
            .wb_data_i(wb_data),
            .occ_i    (occ),
            .valid_i  (valid_q),
            .data_i   (data_flat),
            .ready_o  (lk_ready[g]),
            .data_o   (lk_data[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/reorder_buf.md
REORDER_BUF -- requirements
Module: reorder_buf

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter NWB, default 2, number of writeback ports.
REQ-003 Parameter DATA_W, default 32, result data width.
REQ-004 Parameter REG_W, default 5, architectural register address width.
REQ-005 Derived SEL_W = log2(DEPTH); TAG_W = SEL_W+1; TAG_FREE = all-ones of TAG_W ("no producer").
REQ-006 Reset and clock: reset rst, asynchronous, active-high; clock clk.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 flush  in  1  discard all in-flight entries.
REQ-010 alloc_en  in  1  allocate one entry at tail.
REQ-011 alloc_dest  in  REG_W  destination register of the allocated entry.
REQ-012 alloc_tag  out  TAG_W  tag of the next entry to be allocated, MSB 0.
REQ-013 rob_free  out  1  at least one entry free.
REQ-014 count  out  SEL_W+1  occupied entries.
REQ-015 lk_tag  in  3*TAG_W  three operand lookup tags, packed.
REQ-016 lk_ready  out  3  per-lookup ready flags.
REQ-017 lk_data  out  3*DATA_W  per-lookup data, packed.
REQ-018 wb_en  in  NWB  per-port writeback valid.
REQ-019 wb_tag  in  NWB*TAG_W  writeback tags, packed.
REQ-020 wb_data  in  NWB*DATA_W  writeback data, packed.
REQ-021 com_stall  in  1  regfile cannot accept a commit this cycle.
REQ-022 com_en  out  1  head entry commits this cycle.
REQ-023 com_addr / com_data / com_tag  out  REG_W / DATA_W / TAG_W  head entry contents.

Function
REQ-024 Circular buffer; head and tail pointers SEL_W bits, wrap modulo DEPTH.
REQ-025 rob_free = (count < DEPTH), combinational from registered count.
REQ-026 Allocation accepted when alloc_en && rob_free && !flush: entry valid cleared, dest written, data cleared to 0, tail+1.
REQ-027 alloc_en while full SHALL be ignored with no state change, even if a commit occurs the same cycle.
REQ-028 Writeback port i with wb_en[i] sets data and valid of entry wb_tag[i][SEL_W-1:0] at the next edge.
REQ-029 Writeback to an unoccupied entry, or with tag TAG_FREE, SHALL be ignored.
REQ-030 Two ports writing the same tag in one cycle: highest port index wins.
REQ-031 com_en = valid[head] && count != 0 && !com_stall && !flush, combinational; com_tag = {0, head}.
REQ-032 When com_en: head+1, valid[head] cleared.
REQ-033 Simultaneous accepted alloc and commit: count unchanged, both pointers advance.
REQ-034 Lookup combinational: TAG_FREE -> ready 1, data 0; else matching wb port (highest index first) -> ready 1, bypassed data; else stored valid and data.
REQ-035 Lookup of an unoccupied entry SHALL return ready 0.
REQ-036 flush highest priority: next edge clears all valid, head=tail=0, count=0; same-cycle alloc, writeback and commit discarded.

Reset
REQ-037 On rst: head, tail, count 0; all valid 0; alloc_tag 0; rob_free 1; com_en 0; data and dest arrays not reset.
REQ-038 rst mid-operation SHALL discard all entries immediately, identical to flush but asynchronous.

Structure
REQ-039 Shared package rob_pkg holds TAG_W/SEL_W derivation functions, TAG_FREE constant and default widths.
REQ-040 One sub-module rob_lookup (single-operand bypass/ready mux), instantiated three times.

Verification
REQ-041 Allocate 8 with no writeback (DEPTH 8) -> rob_free 0, count 8; 9th alloc_en ignored, alloc_tag stays 0.
REQ-042 Alloc tags 0..2, writeback tag 1 then tag 0 -> commits of tags 0 and 1 on consecutive cycles, tag 2 held.
REQ-043 wb port 0 and port 1 both tag 3, data 0xA / 0xB -> lk_tag 3 returns 0xB same cycle; stored data 0xB.
REQ-044 Full buffer, head valid, alloc_en and commit together -> commit occurs, alloc ignored, count 7.
REQ-045 Five entries in flight, flush with concurrent wb_en and alloc_en -> next cycle count 0, alloc_tag 0, com_en 0.
REQ-046 Wrap-around: 20 alloc/commit pairs -> com_tag sequence 0..7 repeating, count steady.
